exception_ctrl: RTL
===================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'd112, is the handler entry address.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1-7, is the number of cycles exception_flush is held.
REQ-003 clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 undef_instr  input  1  undefined opcode detected in ID this cycle.
REQ-006 undef_pc  input  32  PC of the ID-stage instruction.
REQ-007 ovf  input  1  arithmetic overflow detected in EX this cycle.
REQ-008 ovf_pc  input  32  PC of the EX-stage instruction.
REQ-009 eret  input  1  handler return request.
REQ-010 exception_flush  output  1  flush IF/ID and clear ID_EX control.
REQ-011 exception_mux_control  output  1  one-cycle PC redirect strobe.
REQ-012 redirect_pc  output  32  PC target, valid while exception_mux_control=1.
REQ-013 epc  output  32  saved faulting PC.
REQ-014 cause  output  2  00 none, 01 undefined, 10 overflow.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 exc_count  output  8  accepted exceptions, saturating at 255.
REQ-017 drop_count  output  4  ignored exceptions, saturating at 15.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, FLUSH, HANDLER, RETURN.
REQ-019 IDLE: if ovf or undef_instr, then at the next edge epc and cause are latched, exc_count increments, flush counter is loaded with FLUSH_CYCLES, and the FSM moves to FLUSH.
REQ-020 Simultaneous ovf and undef_instr in IDLE: ovf wins (older instruction), so epc=ovf_pc and cause=10, exc_count +1, drop_count unchanged.
REQ-021 FLUSH: exception_flush=1 for exactly FLUSH_CYCLES consecutive cycles, then the FSM moves to HANDLER.
REQ-022 exception_mux_control=1 only in the first FLUSH cycle, with redirect_pc=HANDLER_ADDR.
REQ-023 HANDLER: outputs are quiescent except busy; eret moves the FSM to RETURN at the next edge.
REQ-024 RETURN: lasts one cycle; exception_mux_control=1 and redirect_pc=epc+4 (mod 2^32), then the FSM moves to IDLE and cause clears to 00.
REQ-025 eret in IDLE, FLUSH or RETURN SHALL be ignored.
REQ-026 Each cycle with ovf or undef_instr in FLUSH, HANDLER or RETURN SHALL increment drop_count by 1 (one count even if both are high), and SHALL leave epc and cause unchanged.
REQ-027 eret and an exception in the same HANDLER cycle: the FSM goes to RETURN and drop_count increments.
REQ-028 epc+4 SHALL wrap modulo 2^32 (epc=32'hFFFFFFFC gives redirect_pc=0).
REQ-029 Both counters SHALL saturate and never wrap.
REQ-030 redirect_pc SHALL be 0 whenever exception_mux_control=0.
REQ-031 Entry latency: exception sampled at edge N gives exception_flush=1 and exception_mux_control=1 in the cycle after edge N.

Reset
REQ-032 While rst=1, asynchronously: FSM=IDLE, all outputs 0, epc=0, cause=00, both counters 0.
REQ-033 rst asserted mid-FLUSH or mid-HANDLER SHALL abort immediately, with no RETURN redirect issued.
REQ-034 After rst falls, an exception at the first edge SHALL be accepted normally.

Verification
REQ-035 ovf=1, ovf_pc=32'h40 in IDLE -> next cycle: flush=1, mux_ctrl=1, redirect_pc=112, epc=32'h40, cause=10; flush stays high for 2 cycles; busy=1; exc_count=1.
REQ-036 ovf=1 (pc 32'h50) and undef_instr=1 (pc 32'h54) in the same cycle -> epc=32'h50, cause=10, exc_count=1, drop_count=0.
REQ-037 In HANDLER, eret=1 -> one cycle with mux_ctrl=1 and redirect_pc=epc+4 (32'h44), then IDLE with busy=0 and cause=00.
REQ-038 undef_instr pulsed for 3 cycles during HANDLER -> drop_count=3, epc/cause unchanged; 20 further drops -> drop_count=15.
REQ-039 rst pulsed during the second FLUSH cycle -> all outputs 0 immediately; no redirect after release.
REQ-040 epc=32'hFFFFFFFC, then eret -> redirect_pc=32'h0.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// -----------------------------------------------------------------------------
// exception_ctrl_if
// Groups the exception controller's pipeline-facing signals.
//   Pipeline -> controller : undef_instr/undef_pc (ID), ovf/ovf_pc (EX), eret
//   Controller -> pipeline : exception_flush, exception_mux_control,
//                            redirect_pc, epc, cause, busy,
//                            exc_count, drop_count
// Modports: master = pipeline/testbench side, slave = exception_ctrl side.
// -----------------------------------------------------------------------------
interface exception_ctrl_if;
   logic        undef_instr;
   logic [31:0] undef_pc;
   logic        ovf;
   logic [31:0] ovf_pc;
   logic        eret;
   logic        exception_flush;
   logic        exception_mux_control;
   logic [31:0] redirect_pc;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic        busy;
   logic [7:0]  exc_count;
   logic [3:0]  drop_count;

   modport master (
      output undef_instr, undef_pc, ovf, ovf_pc, eret,
      input  exception_flush, exception_mux_control, redirect_pc, epc,
             cause, busy, exc_count, drop_count
   );

   modport slave (
      input  undef_instr, undef_pc, ovf, ovf_pc, eret,
      output exception_flush, exception_mux_control, redirect_pc, epc,
             cause, busy, exc_count, drop_count
   );
endinterface

// File: rtl/exception_ctrl.sv
// -----------------------------------------------------------------------------
// exception_ctrl
// Precise-exception sequencer for a 5-stage pipeline. Accepts an overflow (EX)
// or undefined-instruction (ID) exception while idle, flushes the front of the
// pipe for FLUSH_CYCLES cycles while redirecting fetch to HANDLER_ADDR, waits
// in the handler for eret, then redirects once to epc+4.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - exception_ctrl_if.slave (exception inputs, control/status outputs)
// Parameters:
//   HANDLER_ADDR - handler entry PC
//   FLUSH_CYCLES - cycles exception_flush is held (1..7)
// -----------------------------------------------------------------------------
module exception_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'd112,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   exception_ctrl_if.slave       bus
);

   localparam logic [2:0] FLUSH_LOAD = FLUSH_CYCLES[2:0];

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLUSH   = 2'd1,
      HANDLER = 2'd2,
      RETURN  = 2'd3
   } state_t;

   state_t      state_q,      state_d;
   logic [2:0]  flush_cnt_q,  flush_cnt_d;
   logic [31:0] epc_q,        epc_d;
   logic [1:0]  cause_q,      cause_d;
   logic [7:0]  exc_count_q,  exc_count_d;
   logic [3:0]  drop_count_q, drop_count_d;

   logic        exc_any;
   logic        first_flush;

   assign exc_any = bus.ovf | bus.undef_instr;
   // The counter still holds its load value only during the first flush cycle.
   assign first_flush = (state_q == FLUSH) && (flush_cnt_q == FLUSH_LOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         flush_cnt_q  <= 3'd0;
         epc_q        <= 32'd0;
         cause_q      <= 2'b00;
         exc_count_q  <= 8'd0;
         drop_count_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         epc_q        <= epc_d;
         cause_q      <= cause_d;
         exc_count_q  <= exc_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      epc_d        = epc_q;
      cause_d      = cause_q;
      exc_count_d  = exc_count_q;
      drop_count_d = drop_count_q;

      // Any exception arriving while a previous one is in progress is lost;
      // one count per cycle regardless of how many sources fired.
      if (state_q != IDLE && exc_any && drop_count_q != 4'hF) begin
         drop_count_d = drop_count_q + 4'd1;
      end

      case (state_q)
         IDLE: begin
            if (exc_any) begin
               // Overflow belongs to the older (EX) instruction, so it wins.
               if (bus.ovf) begin
                  epc_d   = bus.ovf_pc;
                  cause_d = 2'b10;
               end else begin
                  epc_d   = bus.undef_pc;
                  cause_d = 2'b01;
               end
               if (exc_count_q != 8'hFF) begin
                  exc_count_d = exc_count_q + 8'd1;
               end
               flush_cnt_d = FLUSH_LOAD;
               state_d     = FLUSH;
            end
         end
         FLUSH: begin
            if (flush_cnt_q <= 3'd1) begin
               flush_cnt_d = 3'd0;
               state_d     = HANDLER;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end
         HANDLER: begin
            if (bus.eret) begin
               state_d = RETURN;
            end
         end
         RETURN: begin
            cause_d = 2'b00;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are pure decodes of registered state so reset clears them at once.
   always_comb begin
      bus.exception_flush       = (state_q == FLUSH);
      bus.exception_mux_control = first_flush || (state_q == RETURN);
      bus.redirect_pc           = 32'd0;
      if (first_flush) begin
         bus.redirect_pc = HANDLER_ADDR;
      end else if (state_q == RETURN) begin
         bus.redirect_pc = epc_q + 32'd4;
      end
      bus.epc        = epc_q;
      bus.cause      = cause_q;
      bus.busy       = (state_q != IDLE);
      bus.exc_count  = exc_count_q;
      bus.drop_count = drop_count_q;
   end

endmodule
